// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period helper and parity helper.
// Both the RX and TX blocks import this package.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take on reset (1 suits an idle-high UART line).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Synchroniser chain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle result strobes.
// Define UART_RX_PARITY_EN for an 8E1 frame and the extra oPARITY_ERR output.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic       iRXD,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oBUSY
`ifdef UART_RX_PARITY_EN
  ,
  output logic       oPARITY_ERR
`endif
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

  uart_rx_state_t r_state;
  uart_rx_state_t w_state_nxt;

  logic                      w_rx;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [2:0]                r_bidx;
  logic [2:0]                w_bidx_nxt;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] w_shreg_nxt;
  logic [UART_DATA_BITS-1:0] r_data;
  logic [UART_DATA_BITS-1:0] w_data_nxt;
  logic                      r_valid;
  logic                      w_valid_nxt;
  logic                      r_ferr;
  logic                      w_ferr_nxt;
  logic                      r_busy;
`ifdef UART_RX_PARITY_EN
  logic                      r_par;
  logic                      w_par_nxt;
  logic                      r_perr;
  logic                      w_perr_nxt;
`endif

  sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
    .i_clk (iCLK_50),
    .i_rst (iRST),
    .i_d   (iRXD),
    .o_q   (w_rx)
  );

  // FSM state register
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    w_bidx_nxt  = r_bidx;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt  = '0;
          w_bidx_nxt = 3'd0;
          if (!w_rx) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {w_rx, r_shreg[UART_DATA_BITS-1:1]};
          if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bidx_nxt = r_bidx + 3'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rx;
          w_state_nxt = STOP;
        end else begin
          w_state_nxt = PARITY;
        end
      end
`endif
      // Leaves at mid-stop-bit so a back-to-back start edge is caught
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (even_parity(r_shreg) != r_par) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_valid_nxt = 1'b1;
              w_data_nxt  = r_shreg;
            end
`else
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_shreg;
`endif
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BREAK;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counters, shift register and registered outputs
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      r_cnt   <= '0;
      r_bidx  <= 3'd0;
      r_shreg <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  assign oDATA      = r_data;
  assign oVALID     = r_valid;
  assign oFRAME_ERR = r_ferr;
  assign oBUSY      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign oPARITY_ERR = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed self-checking bench for uart_rx_byte at 16 clocks per bit.
// Honours UART_RX_PARITY_EN when defined (8E1 frames, parity scenario).
module tb_uart_rx_byte;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_both = 0;
  logic [7:0] vdata[$];
  int         vcyc[$];

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .iCLK_50    (clk),
    .iRST       (rst),
    .iRXD       (rxd),
    .oDATA      (data),
    .oVALID     (valid),
    .oFRAME_ERR (ferr),
    .oBUSY      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .oPARITY_ERR(perr)
`endif
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      n_valid++;
      vdata.push_back(data);
      vcyc.push_back(cyc);
    end
    if (ferr) n_ferr++;
    if (valid && ferr) n_both++;
`ifdef UART_RX_PARITY_EN
    if (perr) n_perr++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bits(input logic b, input int n);
    @(posedge clk);
    #1 rxd = b;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bits(par, CPB);
`endif
    drive_bits(stop, CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_frame(d, ^d, stop);
  endtask

  task automatic idle(input int n);
    drive_bits(1'b1, n);
  endtask

  int v0, f0, p0, n0;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    // 1: single good frame
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'hA5, 1'b1);
    idle(8);
    @(negedge clk);
    check("t1_nvalid", n_valid - v0, 32'd1);
    check("t1_data", {24'd0, data}, 32'hA5);
    check("t1_noferr", n_ferr - f0, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // 2: short low glitch is rejected
    v0 = n_valid; f0 = n_ferr;
    drive_bits(1'b0, 4);
    drive_bits(1'b1, 10);
    @(negedge clk);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_nvalid", n_valid - v0, 32'd0);
    check("t2_nferr", n_ferr - f0, 32'd0);

    // 3: framing error then break, recovery with a good frame
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    drive_bits(1'b0, 3 * CPB);
    idle(2 * CPB);
    @(negedge clk);
    check("t3_nferr", n_ferr - f0, 32'd1);
    check("t3_nvalid", n_valid - v0, 32'd0);
    check("t3_hold", {24'd0, data}, 32'hA5);
    v0 = n_valid;
    send_byte(8'h01, 1'b1);
    idle(8);
    @(negedge clk);
    check("t3_nvalid2", n_valid - v0, 32'd1);
    check("t3_data2", {24'd0, data}, 32'h01);

    // 4: back-to-back frames, no idle gap
    v0 = n_valid; n0 = vdata.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(8);
    @(negedge clk);
    check("t4_nvalid", n_valid - v0, 32'd2);
    if (vdata.size() >= n0 + 2) begin
      check("t4_data0", {24'd0, vdata[n0]}, 32'h00);
      check("t4_data1", {24'd0, vdata[n0+1]}, 32'hFF);
      check("t4_gap", vcyc[n0+1] - vcyc[n0], 32'd160);
    end else begin
      check("t4_count", vdata.size(), n0 + 2);
    end

    // 5: reset in the middle of data bit 3
    v0 = n_valid; f0 = n_ferr;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bits(logic'(8'h5A >> i), CPB);
    drive_bits(1'b1, CPB / 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    idle(12 * CPB);
    @(negedge clk);
    check("t5_nostrobe", (n_valid - v0) + (n_ferr - f0), 32'd0);
    check("t5_rstdata", {24'd0, data}, 32'h00);
    send_byte(8'h5A, 1'b1);
    idle(8);
    @(negedge clk);
    check("t5_nvalid", n_valid - v0, 32'd1);
    check("t5_data", {24'd0, data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch, then correct parity
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(8);
    @(negedge clk);
    check("t6_nperr", n_perr - p0, 32'd1);
    check("t6_nvalid", n_valid - v0, 32'd0);
    check("t6_hold", {24'd0, data}, 32'h5A);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    @(negedge clk);
    check("t6_nvalid2", n_valid - v0, 32'd1);
    check("t6_data", {24'd0, data}, 32'h07);
`else
    p0 = n_perr;
`endif

    check("never_both", n_both, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
